// File: rtl/tc_sram_port_arbiter_if.sv
// Requester-side and SRAM-side signals of the round-robin SRAM port arbiter.
// The arbiter takes the slave view; whoever drives the requesters and models the SRAM takes the master view.
interface tc_sram_port_arbiter_if #(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 128,
  parameter int unsigned BeWidth   = 16
);
  logic [NumReq-1:0]           req_i;
  logic [NumReq-1:0]           we_i;
  logic [NumReq*AddrWidth-1:0] addr_i;
  logic [NumReq*DataWidth-1:0] wdata_i;
  logic [NumReq*BeWidth-1:0]   be_i;
  logic [NumReq-1:0]           gnt_o;
  logic [NumReq-1:0]           rvalid_o;
  logic [DataWidth-1:0]        rdata_o;
  logic                        sram_req_o;
  logic                        sram_we_o;
  logic [AddrWidth-1:0]        sram_addr_o;
  logic [DataWidth-1:0]        sram_wdata_o;
  logic [BeWidth-1:0]          sram_be_o;
  logic [DataWidth-1:0]        sram_rdata_i;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, be_i, sram_rdata_i,
    output gnt_o, rvalid_o, rdata_o,
    output sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, be_i, sram_rdata_i,
    input  gnt_o, rvalid_o, rdata_o,
    input  sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o
  );
endinterface

// File: rtl/tc_sram_port_arbiter.sv
// Round-robin arbiter sharing one SRAM port among NumReq requesters; a
// Latency-deep {valid, idx} pipe routes the response strobe back to the issuer.
module tc_sram_port_arbiter #(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 128,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned Latency   = 1
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  tc_sram_port_arbiter_if.slave bus
);
  localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth;
  localparam int unsigned IdxWidth  = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [IdxWidth-1:0]               rr_q;
  logic [IdxWidth-1:0]               rr_next;
  logic [IdxWidth-1:0]               winner;
  logic                              any_req;
  logic [NumReq-1:0]                 gnt;
  logic [Latency-1:0]                pipe_valid_q;
  logic [Latency-1:0][IdxWidth-1:0]  pipe_idx_q;

  assign any_req = |bus.req_i;

  // Scan from the pointer, wrapping modulo NumReq; the first set request wins.
  always_comb begin
    logic                found;
    logic [31:0]         cand;
    logic [IdxWidth-1:0] cidx;
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    cidx   = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = 32'(rr_q) + 32'(i);
      if (cand >= 32'(NumReq)) begin
        cand = cand - 32'(NumReq);
      end
      cidx = IdxWidth'(cand);
      if (!found && bus.req_i[cidx]) begin
        found  = 1'b1;
        winner = cidx;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (any_req) begin
      gnt[winner] = 1'b1;
    end
  end

  assign bus.gnt_o = gnt;
  assign rr_next   = (winner == IdxWidth'(NumReq - 1)) ? '0 : winner + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else if (any_req) begin
      rr_q <= rr_next;
    end
  end

  // One-hot AND-OR mux; all SRAM payload outputs fall to zero when nothing is granted.
  always_comb begin
    bus.sram_we_o    = 1'b0;
    bus.sram_addr_o  = '0;
    bus.sram_wdata_o = '0;
    bus.sram_be_o    = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (gnt[k]) begin
        bus.sram_we_o    = bus.sram_we_o | bus.we_i[k];
        bus.sram_addr_o  = bus.sram_addr_o  | bus.addr_i[k*AddrWidth +: AddrWidth];
        bus.sram_wdata_o = bus.sram_wdata_o | bus.wdata_i[k*DataWidth +: DataWidth];
        bus.sram_be_o    = bus.sram_be_o    | bus.be_i[k*BeWidth +: BeWidth];
      end
    end
  end

  assign bus.sram_req_o = any_req;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_valid_q[0] <= 1'b0;
      pipe_idx_q[0]   <= '0;
    end else begin
      pipe_valid_q[0] <= any_req;
      pipe_idx_q[0]   <= winner;
    end
  end

  for (genvar gi = 1; gi < Latency; gi++) begin : g_stage
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        pipe_valid_q[gi] <= 1'b0;
        pipe_idx_q[gi]   <= '0;
      end else begin
        pipe_valid_q[gi] <= pipe_valid_q[gi-1];
        pipe_idx_q[gi]   <= pipe_idx_q[gi-1];
      end
    end
  end

  // Writes also produce a strobe, serving as a completion ack.
  always_comb begin
    bus.rvalid_o = '0;
    if (pipe_valid_q[Latency-1]) begin
      bus.rvalid_o[pipe_idx_q[Latency-1]] = 1'b1;
    end
  end

  assign bus.rdata_o = bus.sram_rdata_i;
endmodule
